// File: rtl/gray_seq_ctrl.sv
// -----------------------------------------------------------------------------
// gray_seq_ctrl
//
// Sequencing controller for the RGB-to-grayscale floating-point datapath.
// Accepts one pixel over a valid/ready handshake, holds it on R/G/B, then walks
// the datapath through its four stages (int-to-fp, multiply, add, fp-to-int).
// Each stage waits its latency with the enable low and then pulses that stage's
// register enable. When the last stage is done, the result is offered on an
// output valid/ready handshake.
//
// Optional feature: define GRAY_CNT_EN to count completed pixels on pix_count.
// Without the macro the counter is not built and pix_count reads 16'h0000.
//
// Parameters (each 1..15):
//   I2P_LAT  - wait cycles before i2pEn
//   MUL_LAT  - wait cycles before mulEn
//   MUL_HOLD - consecutive cycles mulEn stays high (flushes blue delay chain)
//   ADD_LAT  - wait cycles before addEn
//   F2I_LAT  - wait cycles before f2iEn
//
// Ports:
//   clk, rst_n              - clock (rising edge), async active-low reset
//   flush                   - synchronous abort back to IDLE (highest priority)
//   in_valid / in_ready     - pixel input handshake
//   in_r, in_g, in_b        - pixel channels
//   R, G, B                 - held pixel driven to the datapath
//   i2pEn, mulEn, addEn, f2iEn - datapath stage-register enables
//   out_valid / out_ready   - result handshake (Y is driven by the datapath)
//   busy                    - high in any state other than IDLE
//   pix_count               - completed pixel count (0 without GRAY_CNT_EN)
// -----------------------------------------------------------------------------
module gray_seq_ctrl #(
    parameter int I2P_LAT  = 1,
    parameter int MUL_LAT  = 3,
    parameter int MUL_HOLD = 6,
    parameter int ADD_LAT  = 3,
    parameter int F2I_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        i2pEn,
    output logic        mulEn,
    output logic        addEn,
    output logic        f2iEn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] pix_count
);

    localparam logic [3:0] I2P_L  = 4'(I2P_LAT);
    localparam logic [3:0] MUL_L  = 4'(MUL_LAT);
    localparam logic [3:0] MUL_H  = 4'(MUL_HOLD);
    localparam logic [3:0] ADD_L  = 4'(ADD_LAT);
    localparam logic [3:0] F2I_L  = 4'(F2I_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_I2P,
        S_MUL,
        S_ADD,
        S_F2I,
        S_DONE
    } state_t;

    state_t     state;
    state_t     stage_next;
    logic [3:0] cnt;
    logic [3:0] lat;
    logic [3:0] hold;
    logic       en_any;

    // Per-stage wait length, enable length and successor.
    always_comb begin
        lat        = 4'd1;
        hold       = 4'd1;
        stage_next = S_IDLE;
        case (state)
            S_I2P: begin
                lat        = I2P_L;
                stage_next = S_MUL;
            end
            S_MUL: begin
                lat        = MUL_L;
                hold       = MUL_H;
                stage_next = S_ADD;
            end
            S_ADD: begin
                lat        = ADD_L;
                stage_next = S_F2I;
            end
            S_F2I: begin
                lat        = F2I_L;
                stage_next = S_DONE;
            end
            default: ;
        endcase
    end

    // Only the current stage's enable can be high, so the OR tells us whether
    // the stage is in its wait phase or its enable phase.
    assign en_any = i2pEn | mulEn | addEn | f2iEn;

    // The 4-bit counter restarts at the wait->enable boundary, so it never has
    // to hold more than 15 even for MUL_LAT + MUL_HOLD up to 30.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            R     <= 8'd0;
            G     <= 8'd0;
            B     <= 8'd0;
            i2pEn <= 1'b0;
            mulEn <= 1'b0;
            addEn <= 1'b0;
            f2iEn <= 1'b0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            i2pEn <= 1'b0;
            mulEn <= 1'b0;
            addEn <= 1'b0;
            f2iEn <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        R     <= in_r;
                        G     <= in_g;
                        B     <= in_b;
                        cnt   <= 4'd0;
                        state <= S_I2P;
                    end
                end
                S_I2P, S_MUL, S_ADD, S_F2I: begin
                    if (!en_any) begin
                        if (cnt == lat - 4'd1) begin
                            cnt   <= 4'd0;
                            i2pEn <= (state == S_I2P);
                            mulEn <= (state == S_MUL);
                            addEn <= (state == S_ADD);
                            f2iEn <= (state == S_F2I);
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end else begin
                        if (cnt == hold - 4'd1) begin
                            cnt   <= 4'd0;
                            i2pEn <= 1'b0;
                            mulEn <= 1'b0;
                            addEn <= 1'b0;
                            f2iEn <= 1'b0;
                            state <= stage_next;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

`ifdef GRAY_CNT_EN
    logic [15:0] pix_count_q;

    // Flush wins over a completing handshake, so an aborted DONE is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_count_q <= 16'h0000;
        end else if (!flush && out_valid && out_ready) begin
            pix_count_q <= pix_count_q + 16'h0001;
        end
    end

    assign pix_count = pix_count_q;
`else
    assign pix_count = 16'h0000;
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
module tb_gray_seq_ctrl;

    localparam int LAT_DEF = 1 + 3 + 6 + 3 + 1 + 3;   // 17

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_r, in_g, in_b;
    logic [7:0]  R, G, B;
    logic        i2pEn, mulEn, addEn, f2iEn;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [15:0] pix_count;

    // shared stimulus for the two parameter-corner instances
    logic        in_valid_c;
    logic        out_ready_c;

    logic        mn_in_ready, mn_i2p, mn_mul, mn_add, mn_f2i, mn_ov, mn_busy;
    logic [7:0]  mn_r, mn_g, mn_b;
    logic [15:0] mn_cnt;
    logic        mx_in_ready, mx_i2p, mx_mul, mx_add, mx_f2i, mx_ov, mx_busy;
    logic [7:0]  mx_r, mx_g, mx_b;
    logic [15:0] mx_cnt;

    gray_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .R(R), .G(G), .B(B),
        .i2pEn(i2pEn), .mulEn(mulEn), .addEn(addEn), .f2iEn(f2iEn),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .pix_count(pix_count)
    );

    gray_seq_ctrl #(.I2P_LAT(1), .MUL_LAT(1), .MUL_HOLD(1), .ADD_LAT(1), .F2I_LAT(1)) u_min (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in_valid_c), .in_ready(mn_in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .R(mn_r), .G(mn_g), .B(mn_b),
        .i2pEn(mn_i2p), .mulEn(mn_mul), .addEn(mn_add), .f2iEn(mn_f2i),
        .out_valid(mn_ov), .out_ready(out_ready_c),
        .busy(mn_busy), .pix_count(mn_cnt)
    );

    gray_seq_ctrl #(.I2P_LAT(15), .MUL_LAT(15), .MUL_HOLD(15), .ADD_LAT(15), .F2I_LAT(15)) u_max (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(in_valid_c), .in_ready(mx_in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .R(mx_r), .G(mx_g), .B(mx_b),
        .i2pEn(mx_i2p), .mulEn(mx_mul), .addEn(mx_add), .f2iEn(mx_f2i),
        .out_valid(mx_ov), .out_ready(out_ready_c),
        .busy(mx_busy), .pix_count(mx_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, act, exp);
        end
    endtask

    // Expected {i2pEn, mulEn, addEn, f2iEn, out_valid} k cycles after the
    // accepting edge, straight from the stage-timeline arithmetic.
    function automatic logic [4:0] exp_vec(int k, int i, int m, int h, int a, int f);
        int L;
        logic [4:0] v;
        L    = i + m + h + a + f + 3;
        v[4] = (k == i + 1);
        v[3] = (k > i + 1 + m) && (k <= i + 1 + m + h);
        v[2] = (k == i + 1 + m + h + a + 1);
        v[1] = (k == L);
        v[0] = (k > L);
        return v;
    endfunction

    // Reference model for the default-parameter instance
    bit          m_active;
    int          m_k;
    logic [23:0] m_rgb;
    logic [15:0] m_cnt;
    int          cyc;

    task automatic model_reset();
        m_active = 0;
        m_k      = 0;
        m_rgb    = 24'h0;
        m_cnt    = 16'h0;
    endtask

    task automatic model_update();
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            m_active = 0;
        end else if (!m_active) begin
            if (in_valid) begin
                m_active = 1;
                m_k      = 1;
                m_rgb    = {in_r, in_g, in_b};
            end
        end else if (m_k > LAT_DEF) begin
            if (out_ready) begin
                m_active = 0;
`ifdef GRAY_CNT_EN
                m_cnt = m_cnt + 16'd1;
`endif
            end
        end else begin
            m_k++;
        end
    endtask

    task automatic check_all();
        logic [4:0] v;
        v = m_active ? exp_vec(m_k, 1, 3, 6, 3, 1) : 5'b0;
        chk("rgb", {8'h0, R, G, B}, {8'h0, m_rgb});
        chk("enables", {28'h0, i2pEn, mulEn, addEn, f2iEn}, {28'h0, v[4:1]});
        chk("ctl_rdy_ov_busy", {29'h0, in_ready, out_valid, busy},
            {29'h0, !m_active, v[0], m_active});
        chk("pix_count", {16'h0, pix_count}, {16'h0, m_cnt});
        chk("onehot_en", 32'($countones({i2pEn, mulEn, addEn, f2iEn}) <= 1), 32'd1);
    endtask

    // one clock: model follows the edge, outputs checked on the falling edge
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int acc_cyc[$];
        int run;
        logic [4:0] vmn, vmx;

        cyc = 0;
        model_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_r = 8'h0; in_g = 8'h0; in_b = 8'h0;
        in_valid_c = 1'b0; out_ready_c = 1'b0;

        // reset values
        @(negedge clk);
        check_all();
        step();
        rst_n = 1'b1;
        step();

        // single pixel, then 10 cycles of backpressure in DONE
        in_valid = 1'b1; in_r = 8'h80; in_g = 8'h40; in_b = 8'h20;
        step();
        in_valid = 1'b0; in_r = 8'h11; in_g = 8'h22; in_b = 8'h33;
        repeat (LAT_DEF + 10) step();
        chk("done_hold_ov", {31'h0, out_valid}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("done_to_idle", {31'h0, in_ready}, 32'd1);

        // back-to-back: in_valid held high for three pixels
        in_valid = 1'b1;
        while (acc_cyc.size() < 3 && cyc < 200) begin
            in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
            if (in_ready) acc_cyc.push_back(cyc + 1);
            step();
        end
        in_valid = 1'b0;
        chk("b2b_accepts", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            chk("b2b_gap0", acc_cyc[1] - acc_cyc[0], LAT_DEF + 2);
            chk("b2b_gap1", acc_cyc[2] - acc_cyc[1], LAT_DEF + 2);
        end
        repeat (LAT_DEF + 3) step();

        // flush in MUL at cycle 8
        in_valid = 1'b1; in_r = 8'hA5; in_g = 8'h5A; in_b = 8'h3C;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        chk("pre_flush_mul", {31'h0, mulEn}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (12) step();

        // asynchronous reset pulse in ADD (cycle 13)
        in_valid = 1'b1; in_r = 8'h01; in_g = 8'h02; in_b = 8'h03;
        step();
        in_valid = 1'b0;
        repeat (12) step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
        rst_n = 1'b1;
        step();

        // randomized traffic
        repeat (1500) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 1) == 1);
            flush     = ($urandom_range(0, 99) < 3);
            in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (LAT_DEF + 3) step();

`ifdef GRAY_CNT_EN
        // counter wrap from 0xFFFF
        force dut.pix_count_q = 16'hFFFF;
        #1 release dut.pix_count_q;
        m_cnt = 16'hFFFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (LAT_DEF + 3) step();
        chk("wrap", {16'h0, pix_count}, 32'h0);
`endif

        // parameter corners: L=8 and L=78 (mulEn high 15 cycles)
        in_valid_c = 1'b1;
        step();
        in_valid_c = 1'b0;
        run = 0;
        for (int k = 1; k <= 80; k++) begin
            vmn = exp_vec(k, 1, 1, 1, 1, 1);
            vmx = exp_vec(k, 15, 15, 15, 15, 15);
            chk("min_vec", {27'h0, mn_i2p, mn_mul, mn_add, mn_f2i, mn_ov}, {27'h0, vmn});
            chk("max_vec", {27'h0, mx_i2p, mx_mul, mx_add, mx_f2i, mx_ov}, {27'h0, vmx});
            if (mx_mul) run++;
            step();
        end
        chk("max_mul_run", run, 15);
        out_ready_c = 1'b1;
        step();
        chk("corner_idle", {30'h0, mn_in_ready, mx_in_ready}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
